eth_rx_pkt_reader: RTL and testbench

- Downstream consumer of the Ethernet receive FSM's packet memory.
- Tracks completed packets, one per SLOT_BYTES-aligned slot, and reads each slot's bytes over a 1-cycle-latency RAM read port.
- Emits each packet as a byte stream with valid/ready/last.
- Once every stored packet is drained, asserts the write-address reset so the receive FSM rewinds to slot 0.

---
 rtl/eth_rx_pkt_reader_if.sv | 20 ++
 rtl/eth_rx_pkt_reader.sv | 206 ++++++++++++++++++++
 tb/tb_eth_rx_pkt_reader.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_pkt_reader_if.sv
// Reader-side bus: RAM read port toward the packet memory plus the outgoing byte stream.
interface eth_rx_pkt_reader_if;
  logic        mem_rd_en;
  logic [15:0] mem_rd_addr;
  logic [7:0]  mem_rd_data;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (
    output mem_rd_en, mem_rd_addr, tdata, tvalid, tlast,
    input  mem_rd_data, tready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, tdata, tvalid, tlast,
    output mem_rd_data, tready
  );
endinterface

// File: rtl/eth_rx_pkt_reader.sv
// Drains packets stored by the Ethernet receive FSM out of packet RAM as a byte stream,
// then asks the receive FSM to rewind its write address once every stored packet is consumed.
module eth_rx_pkt_reader #(
  parameter int SLOT_BYTES   = 1024,
  parameter int MAX_SLOTS    = 63,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                i_eth_clk,
  input  logic                i_rst,
  input  logic                i_valid_packet,
  input  logic [15:0]         i_pkt_len,
  input  logic                i_busy,
  eth_rx_pkt_reader_if.master bus,
  output logic                o_rst_waddr,
  output logic [6:0]          o_pkt_pending,
  output logic [15:0]         o_drop_count
);

  localparam int IDX_W = (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1;
  localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_DRAIN,
    S_FLUSH
  } state_t;

  state_t state, state_nxt;

  logic [15:0]     len_tbl [MAX_SLOTS];
  logic [15:0]     tbl_len;
  logic [15:0]     clamped_len;
  logic [6:0]      wr_slot;
  logic [6:0]      rd_slot;
  logic            accept;
  logic            retire;
  logic            flush_done;

  logic [15:0]     len;
  logic [15:0]     byte_cnt;
  logic [15:0]     base;
  logic [FC_W-1:0] flush_cnt;

  logic            rd_issue;
  logic            rd_inflight;
  logic            rd_inflight_last;

  logic [8:0]      fifo_mem [2];
  logic            fifo_wp;
  logic            fifo_rp;
  logic [1:0]      fifo_cnt;
  logic            tvalid_int;
  logic            push;
  logic            pop;
  logic [2:0]      fill;

  assign clamped_len = (i_pkt_len > 16'(SLOT_BYTES)) ? 16'(SLOT_BYTES) : i_pkt_len;
  assign accept      = i_valid_packet && (wr_slot < 7'(MAX_SLOTS)) && (state != S_FLUSH);
  assign tbl_len     = len_tbl[rd_slot[IDX_W-1:0]];

  assign tvalid_int = (fifo_cnt != 2'd0);
  assign pop        = tvalid_int && bus.tready;
  assign push       = rd_inflight;
  // A beat leaving this cycle frees its entry, so a new read may be issued into it.
  assign fill       = 3'(fifo_cnt) + 3'(rd_inflight) - 3'(pop);

  always_ff @(posedge i_eth_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rd_issue    = 1'b0;
    retire      = 1'b0;
    flush_done  = 1'b0;
    o_rst_waddr = 1'b0;
    case (state)
      S_IDLE: begin
        if (rd_slot < wr_slot) begin
          state_nxt = S_LOAD;
        end else if ((wr_slot != 7'd0) && !i_busy && !i_valid_packet) begin
          state_nxt = S_FLUSH;
        end
      end
      S_LOAD: begin
        if (tbl_len == 16'd0) begin
          retire    = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        if ((byte_cnt < len) && (fill < 3'd2)) begin
          rd_issue = 1'b1;
          if (byte_cnt + 16'd1 == len) begin
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if ((fifo_cnt == 2'd0) && !rd_inflight) begin
          retire    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_FLUSH: begin
        o_rst_waddr = 1'b1;
        if (flush_cnt == FC_W'(FLUSH_CYCLES - 1)) begin
          flush_done = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_eth_clk) begin
    if (i_rst) begin
      len       <= '0;
      byte_cnt  <= '0;
      base      <= '0;
      flush_cnt <= '0;
    end else begin
      if (state == S_LOAD) begin
        len      <= tbl_len;
        byte_cnt <= '0;
        base     <= 16'(32'(rd_slot) * SLOT_BYTES);
      end else if (rd_issue) begin
        byte_cnt <= byte_cnt + 16'd1;
      end
      flush_cnt <= (state == S_FLUSH) ? flush_cnt + 1'b1 : '0;
    end
  end

  // Accepts and retirements are independent, so both counters may move in one cycle.
  always_ff @(posedge i_eth_clk) begin
    if (i_rst) begin
      wr_slot      <= '0;
      rd_slot      <= '0;
      o_drop_count <= '0;
    end else begin
      if (flush_done) begin
        wr_slot <= '0;
      end else if (accept) begin
        wr_slot <= wr_slot + 7'd1;
      end
      if (flush_done) begin
        rd_slot <= '0;
      end else if (retire) begin
        rd_slot <= rd_slot + 7'd1;
      end
      if (i_valid_packet && !accept && (o_drop_count != 16'hFFFF)) begin
        o_drop_count <= o_drop_count + 16'd1;
      end
    end
  end

  always_ff @(posedge i_eth_clk) begin
    if (accept && !i_rst) begin
      len_tbl[wr_slot[IDX_W-1:0]] <= clamped_len;
    end
  end

  always_ff @(posedge i_eth_clk) begin
    if (i_rst) begin
      rd_inflight      <= 1'b0;
      rd_inflight_last <= 1'b0;
    end else begin
      rd_inflight      <= rd_issue;
      rd_inflight_last <= rd_issue && (byte_cnt == len - 16'd1);
    end
  end

  // Two-entry skid buffer; the last-byte tag travels alongside each data byte.
  always_ff @(posedge i_eth_clk) begin
    if (i_rst) begin
      fifo_wp  <= 1'b0;
      fifo_rp  <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[fifo_wp] <= {rd_inflight_last, bus.mem_rd_data};
        fifo_wp           <= ~fifo_wp;
      end
      if (pop) begin
        fifo_rp <= ~fifo_rp;
      end
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
    end
  end

  assign bus.tvalid      = tvalid_int;
  assign bus.tdata       = tvalid_int ? fifo_mem[fifo_rp][7:0] : 8'd0;
  assign bus.tlast       = tvalid_int ? fifo_mem[fifo_rp][8] : 1'b0;
  assign bus.mem_rd_en   = rd_issue;
  assign bus.mem_rd_addr = base + byte_cnt;
  assign o_pkt_pending   = wr_slot - rd_slot;

endmodule

// File: tb/tb_eth_rx_pkt_reader.sv
// Self-checking bench: packet RAM model plus a queue-based model of the expected byte stream.
module tb_eth_rx_pkt_reader;

  localparam int SLOT_BYTES   = 1024;
  localparam int MAX_SLOTS    = 63;
  localparam int FLUSH_CYCLES = 4;

  logic        clk;
  logic        i_rst;
  logic        i_valid_packet;
  logic [15:0] i_pkt_len;
  logic        i_busy;
  logic        o_rst_waddr;
  logic [6:0]  o_pkt_pending;
  logic [15:0] o_drop_count;

  eth_rx_pkt_reader_if bus();

  eth_rx_pkt_reader #(
    .SLOT_BYTES  (SLOT_BYTES),
    .MAX_SLOTS   (MAX_SLOTS),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .i_eth_clk     (clk),
    .i_rst         (i_rst),
    .i_valid_packet(i_valid_packet),
    .i_pkt_len     (i_pkt_len),
    .i_busy        (i_busy),
    .bus           (bus),
    .o_rst_waddr   (o_rst_waddr),
    .o_pkt_pending (o_pkt_pending),
    .o_drop_count  (o_drop_count)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem [65536];
  logic [8:0]  exp_q [$];
  logic [15:0] addr_log [$];
  int          beat_cyc [$];
  int          m_wr = 0;
  int          m_drop = 0;
  int          cyc = 0;
  int          flush_events = 0;
  int          flush_run = 0;
  int          last_run = 0;
  int          tready_mode = 0;
  logic        tready_fixed = 1'b1;
  int          pat_idx = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic modelPacket(input int len);
    int n;
    int base;
    if (m_wr < MAX_SLOTS) begin
      n    = (len > SLOT_BYTES) ? SLOT_BYTES : len;
      base = m_wr * SLOT_BYTES;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({1'(i == n - 1), mem[(base + i) & 16'hFFFF]});
      end
      m_wr++;
    end else begin
      m_drop++;
    end
  endtask

  task automatic applyStimulus(input int len);
    i_valid_packet = 1'b1;
    i_pkt_len      = 16'(len);
    waitCycles(1);
    i_valid_packet = 1'b0;
    modelPacket(len);
  endtask

  task automatic waitDrain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      waitCycles(1);
      n++;
    end
    checkOutput("drain_left", exp_q.size(), 0);
  endtask

  task automatic waitFlush(input int fe0);
    int n;
    n = 0;
    while (flush_events == fe0 && n < 300) begin
      waitCycles(1);
      n++;
    end
    checkOutput("flush_seen", flush_events, fe0 + 1);
    checkOutput("flush_len", last_run, FLUSH_CYCLES);
    m_wr = 0;
    checkOutput("pending_after_flush", o_pkt_pending, 0);
  endtask

  function automatic logic [31:0] logAddr(input int k);
    if (k < addr_log.size()) return 32'(addr_log[k]);
    return 32'hFFFF_FFFF;
  endfunction

  initial begin
    bus.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0: bus.tready = tready_fixed;
        1: bus.tready = ($urandom_range(0, 3) != 0);
        default: begin
          bus.tready = (pat_idx == 0) || (pat_idx == 3);
          pat_idx    = (pat_idx + 1) % 4;
        end
      endcase
    end
  end

  // Stream monitor: every transferred beat is compared against the head of the model queue.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (i_rst) begin
        flush_run = 0;
      end else begin
        if (bus.mem_rd_en) addr_log.push_back(bus.mem_rd_addr);
        if (bus.tvalid && bus.tready) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_beat", {23'd0, bus.tlast, bus.tdata}, 32'h1FF);
          end else begin
            e = exp_q.pop_front();
            checkOutput("beat_data", bus.tdata, e[7:0]);
            checkOutput("beat_last", bus.tlast, e[8]);
            beat_cyc.push_back(cyc);
          end
        end else if (bus.tvalid && exp_q.size() != 0) begin
          checkOutput("stall_head", {bus.tlast, bus.tdata}, exp_q[0]);
        end
        if (o_rst_waddr) begin
          flush_run++;
        end else if (flush_run > 0) begin
          flush_events++;
          last_run  = flush_run;
          flush_run = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fe0;
    int a0;
    int b0;
    i_rst          = 1'b1;
    i_valid_packet = 1'b0;
    i_pkt_len      = '0;
    i_busy         = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) mem[i] = 8'(8'hA0 + i);

    waitCycles(3);
    checkOutput("rst_tvalid", bus.tvalid, 0);
    checkOutput("rst_tdata", bus.tdata, 0);
    checkOutput("rst_tlast", bus.tlast, 0);
    checkOutput("rst_rd_en", bus.mem_rd_en, 0);
    checkOutput("rst_rd_addr", bus.mem_rd_addr, 0);
    checkOutput("rst_waddr", o_rst_waddr, 0);
    checkOutput("rst_pending", o_pkt_pending, 0);
    checkOutput("rst_drops", o_drop_count, 0);
    i_rst = 1'b0;
    waitCycles(2);

    $display("[TB] single 5-byte packet");
    fe0 = flush_events;
    b0  = beat_cyc.size();
    applyStimulus(5);
    waitDrain(200);
    checkOutput("t1_beats", beat_cyc.size() - b0, 5);
    if (beat_cyc.size() - b0 == 5) checkOutput("t1_consecutive", beat_cyc[b0 + 4] - beat_cyc[b0], 4);
    waitFlush(fe0);

    $display("[TB] two back-to-back 3-byte packets");
    i_busy = 1'b1;
    fe0 = flush_events;
    a0  = addr_log.size();
    applyStimulus(3);
    applyStimulus(3);
    waitDrain(200);
    checkOutput("t2_reads", addr_log.size() - a0, 6);
    checkOutput("t2_addr0", logAddr(a0), 0);
    checkOutput("t2_addr_slot1", logAddr(a0 + 3), SLOT_BYTES);
    i_busy = 1'b0;
    waitFlush(fe0);

    $display("[TB] 16-byte packet with toggling ready");
    tready_mode = 2;
    pat_idx = 0;
    fe0 = flush_events;
    b0  = beat_cyc.size();
    applyStimulus(16);
    waitDrain(400);
    checkOutput("t3_beats", beat_cyc.size() - b0, 16);
    tready_mode = 0;
    waitFlush(fe0);

    $display("[TB] zero-length packet then 2-byte packet");
    i_busy = 1'b1;
    fe0 = flush_events;
    a0  = addr_log.size();
    applyStimulus(0);
    applyStimulus(2);
    waitDrain(200);
    checkOutput("t4_reads", addr_log.size() - a0, 2);
    checkOutput("t4_addr_a", logAddr(a0), SLOT_BYTES);
    checkOutput("t4_addr_b", logAddr(a0 + 1), SLOT_BYTES + 1);
    i_busy = 1'b0;
    waitFlush(fe0);

    $display("[TB] table overflow with stalled sink");
    tready_fixed = 1'b0;
    i_busy = 1'b1;
    waitCycles(2);
    fe0 = flush_events;
    b0  = beat_cyc.size();
    applyStimulus(2000);
    for (int p = 1; p < 64; p++) applyStimulus(1);
    waitCycles(3);
    checkOutput("t5_pending_full", o_pkt_pending, 63);
    checkOutput("t5_drops", o_drop_count, m_drop);
    checkOutput("t5_model_drops", m_drop, 1);
    tready_fixed = 1'b1;
    waitDrain(5000);
    checkOutput("t5_beats", beat_cyc.size() - b0, 1024 + 62);
    waitCycles(10);
    checkOutput("t5_no_flush_busy", flush_events, fe0);
    checkOutput("t5_waddr_low_busy", o_rst_waddr, 0);
    i_busy = 1'b0;
    waitFlush(fe0);

    $display("[TB] pulse coincident with would-be flush");
    i_busy = 1'b1;
    fe0 = flush_events;
    applyStimulus(3);
    waitDrain(200);
    waitCycles(4);
    i_busy = 1'b0;
    applyStimulus(4);
    waitDrain(200);
    waitFlush(fe0);
    checkOutput("t6_drops", o_drop_count, m_drop);

    $display("[TB] randomized packet bursts");
    for (int r = 0; r < 6; r++) begin
      int npk;
      tready_mode = 1;
      i_busy = 1'b1;
      fe0 = flush_events;
      npk = $urandom_range(1, 5);
      for (int p = 0; p < npk; p++) begin
        applyStimulus($urandom_range(0, 40));
        waitCycles($urandom_range(0, 3));
      end
      waitDrain(2000);
      i_busy = 1'b0;
      waitFlush(fe0);
      checkOutput("rnd_drops", o_drop_count, m_drop);
    end
    tready_mode = 0;

    $display("[TB] reset mid-stream");
    tready_fixed = 1'b0;
    i_busy = 1'b1;
    waitCycles(2);
    fe0 = flush_events;
    applyStimulus(20);
    waitCycles(8);
    checkOutput("t7_tvalid_before", bus.tvalid, 1);
    i_rst = 1'b1;
    exp_q.delete();
    m_wr = 0;
    m_drop = 0;
    waitCycles(1);
    checkOutput("t7_tvalid_after", bus.tvalid, 0);
    checkOutput("t7_tlast_after", bus.tlast, 0);
    waitCycles(1);
    i_rst = 1'b0;
    i_busy = 1'b0;
    tready_fixed = 1'b1;
    waitCycles(20);
    checkOutput("t7_pending", o_pkt_pending, 0);
    checkOutput("t7_drops", o_drop_count, m_drop);
    checkOutput("t7_no_flush", flush_events, fe0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
